// File: rtl/led_anim_ctrl.sv
// led_anim_ctrl: frame sequencer for the 8x8 LED matrix scanner.
// A prescaler sets the frame rate; sel steps through frames 0..3 while
// enabled. A trigger rising edge shows the alternate pattern for
// HOLD_FRAMES frame ticks, then animation resumes.
// Optional build macro: LED_ANIM_PINGPONG_EN (bounce 0,1,2,3,2,1,0,... and
// ignore dir).
module led_anim_ctrl #(
  parameter int unsigned TICK_DIV    = 25000000,
  parameter int unsigned HOLD_FRAMES = 8,
  parameter int unsigned PS_W        = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       trigger,
  input  logic       dir,
  output logic [1:0] sel,
  output logic       pattern,
  output logic       frame_tick,
  output logic       holding
);

  localparam int unsigned HC_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e          state_q, state_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [HC_W-1:0] hc_q, hc_d;
  logic [1:0]      sel_q, sel_d;
  logic            trig_q;
  logic            pattern_q, holding_q, tick_q;

  logic running, wrap, trig_rise, step, step_rev;

`ifdef LED_ANIM_PINGPONG_EN
  // Internal bounce direction: 0 = forward, 1 = reverse.
  logic pdir_q, pdir_d;
  logic unused_dir;
  assign unused_dir = dir;
  assign step_rev   = pdir_q;
`else
  assign step_rev   = dir;
`endif

  // Prescaler, trigger edge detect, state transitions and frame stepping.
  always_comb begin
    running   = (state_q != StIdle);
    wrap      = running && (ps_q == PS_LAST);
    trig_rise = trigger & ~trig_q;

    if (wrap)         ps_d = '0;
    else if (running) ps_d = ps_q + PS_W'(1);
    else              ps_d = ps_q;

    state_d = state_q;
    hc_d    = hc_q;
    step    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (trig_rise) begin
          state_d = StHold;
          hc_d    = '0;
        end else if (enable) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // Trigger beats disable, and disable beats a coincident step.
        if (trig_rise) begin
          state_d = StHold;
          hc_d    = '0;
        end else if (!enable) begin
          state_d = StIdle;
        end else if (wrap) begin
          step = 1'b1;
        end
      end
      StHold: begin
        if (wrap) begin
          if (hc_q == HC_LAST) state_d = enable ? StRun : StIdle;
          else                 hc_d    = hc_q + HC_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    sel_d = sel_q;
    if (step) sel_d = step_rev ? (sel_q - 2'd1) : (sel_q + 2'd1);

`ifdef LED_ANIM_PINGPONG_EN
    // Turn around on arriving at either end of the frame range.
    pdir_d = pdir_q;
    if (step) begin
      if (!pdir_q && (sel_d == 2'd3))     pdir_d = 1'b1;
      else if (pdir_q && (sel_d == 2'd0)) pdir_d = 1'b0;
    end
`endif
  end

  // State and output registers; all outputs follow the next state by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ps_q      <= '0;
      hc_q      <= '0;
      sel_q     <= 2'd0;
      trig_q    <= 1'b0;
      pattern_q <= 1'b0;
      holding_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ps_q      <= ps_d;
      hc_q      <= hc_d;
      sel_q     <= sel_d;
      trig_q    <= trigger;
      pattern_q <= (state_d == StHold);
      holding_q <= (state_d == StHold);
      tick_q    <= wrap;
    end
  end

`ifdef LED_ANIM_PINGPONG_EN
  // Bounce direction register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pdir_q <= 1'b0;
    else     pdir_q <= pdir_d;
  end
`endif

  assign sel        = sel_q;
  assign pattern    = pattern_q;
  assign holding    = holding_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_led_anim_ctrl.sv
// tb_led_anim_ctrl: self-checking bench for led_anim_ctrl with TICK_DIV=4,
// HOLD_FRAMES=3, against a frame-level behavioural model.
module tb_led_anim_ctrl;

  localparam int TD = 4;
  localparam int HF = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       trigger;
  logic       dir;
  logic [1:0] sel;
  logic       pattern;
  logic       frame_tick;
  logic       holding;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode 0 = idle, 1 = animating, 2 = showing alternate.
  int         m_mode;
  int         m_phase;
  int         m_frames;
  logic       m_trig;
  logic [1:0] m_sel;
  logic       m_pat;
  logic       m_tick;
  logic       m_bounce_rev;

  led_anim_ctrl #(
    .TICK_DIV   (TD),
    .HOLD_FRAMES(HF),
    .PS_W       (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .trigger   (trigger),
    .dir       (dir),
    .sel       (sel),
    .pattern   (pattern),
    .frame_tick(frame_tick),
    .holding   (holding)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_frames = 0; m_trig = 1'b0;
    m_sel = 2'd0; m_pat = 1'b0; m_tick = 1'b0; m_bounce_rev = 1'b0;
  endtask

  // One clock edge of the model, from the inputs present before the edge.
  task automatic model_next();
    bit end_of_frame, rise, advance;
    int nxt;
    end_of_frame = (m_mode != 0) && (m_phase == TD - 1);
    rise         = trigger && !m_trig;
    advance      = 0;
    nxt          = m_mode;
    if (m_mode == 0) begin
      if (rise) begin nxt = 2; m_frames = 0; end
      else if (enable) nxt = 1;
    end else if (m_mode == 1) begin
      if (rise) begin nxt = 2; m_frames = 0; end
      else if (!enable) nxt = 0;
      else if (end_of_frame) advance = 1;
    end else if (end_of_frame) begin
      m_frames++;
      if (m_frames == HF) nxt = enable ? 1 : 0;
    end
    if (m_mode != 0) m_phase = (m_phase + 1) % TD;
    if (advance) begin
`ifdef LED_ANIM_PINGPONG_EN
      m_sel = m_bounce_rev ? m_sel - 2'd1 : m_sel + 2'd1;
      if (m_sel == 2'd3) m_bounce_rev = 1'b1;
      if (m_sel == 2'd0) m_bounce_rev = 1'b0;
`else
      m_sel = dir ? m_sel - 2'd1 : m_sel + 2'd1;
`endif
    end
    m_mode = nxt;
    m_tick = end_of_frame;
    m_pat  = (nxt == 2);
    m_trig = trigger;
  endtask

  task automatic step();
    if (rst) model_reset();
    else     model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; trigger = 1'b0; dir = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({sel, pattern, holding, frame_tick} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_async: sel=%0d pat=%0b hold=%0b tick=%0b, want all 0",
               sel, pattern, holding, frame_tick);
    end
    for (int i = 0; i < 3; i++) begin
      trigger = 1'($urandom_range(0, 1));
      step();
      n_checks++;
      if ({sel, pattern, holding, frame_tick} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_held: sel=%0d pat=%0b hold=%0b tick=%0b, want all 0",
                 sel, pattern, holding, frame_tick);
      end
    end
    trigger = 1'b0;
    rst = 1'b0;
  endtask

`ifdef LED_ANIM_PINGPONG_EN
  task automatic test_pingpong();
    logic [1:0] want [8];
    int seen;
    want = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2};
    rst = 1'b1; #1; model_reset(); step(); rst = 1'b0;
    enable = 1'b1; trigger = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && seen < 8; i++) begin
      dir = 1'($urandom_range(0, 1));
      step();
      if (frame_tick) begin
        n_checks++;
        if (sel !== want[seen]) begin
          n_fail++;
          $display("FAIL pingpong_seq[%0d]: sel=%0d, want %0d", seen, sel, want[seen]);
        end
        seen++;
      end
    end
    n_checks++;
    if (seen != 8) begin
      n_fail++;
      $display("FAIL pingpong_ticks: saw %0d ticks, want 8", seen);
    end
  endtask
`endif

  task automatic test_forward();
    int last_tick, gaps_bad;
    enable = 1'b1; dir = 1'b0; trigger = 1'b0;
    last_tick = -1; gaps_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if ({sel, pattern, holding, frame_tick} !== {m_sel, m_pat, m_pat, m_tick}) begin
        n_fail++;
        $display("FAIL forward: sel=%0d pat=%0b hold=%0b tick=%0b, want sel=%0d pat=%0b tick=%0b",
                 sel, pattern, holding, frame_tick, m_sel, m_pat, m_tick);
      end
      if (frame_tick) begin
        if (last_tick >= 0 && i - last_tick != TD) gaps_bad++;
        last_tick = i;
      end
    end
    n_checks++;
    if (gaps_bad != 0 || last_tick < 0) begin
      n_fail++;
      $display("FAIL tick_period: %0d bad gaps (last tick %0d), want 0 and ticks every %0d",
               gaps_bad, last_tick, TD);
    end
  endtask

  task automatic test_reverse_pause();
    dir = 1'b1; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) enable = 1'b0;
      if (i == 8) enable = 1'b1;
      step();
      n_checks++;
      if ({sel, pattern, holding, frame_tick} !== {m_sel, m_pat, m_pat, m_tick}) begin
        n_fail++;
        $display("FAIL rev_pause: sel=%0d pat=%0b hold=%0b tick=%0b, want sel=%0d pat=%0b tick=%0b",
                 sel, pattern, holding, frame_tick, m_sel, m_pat, m_tick);
      end
    end
    for (int i = 0; i < 16; i++) begin
      step();
      n_checks++;
      if ({sel, pattern, holding, frame_tick} !== {m_sel, m_pat, m_pat, m_tick}) begin
        n_fail++;
        $display("FAIL rev_resume: sel=%0d pat=%0b hold=%0b tick=%0b, want sel=%0d pat=%0b tick=%0b",
                 sel, pattern, holding, frame_tick, m_sel, m_pat, m_tick);
      end
    end
  endtask

  task automatic test_trigger_pulse();
    int hold_ticks;
    logic prev_hold;
    enable = 1'b1; dir = 1'b0; trigger = 1'b0;
    for (int i = 0; i < 60 && !(m_sel == 2'd2 && m_mode == 1); i++) step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    n_checks++;
    if ({pattern, holding} !== 2'b11) begin
      n_fail++;
      $display("FAIL trig_entry: pat=%0b hold=%0b, want 1 1", pattern, holding);
    end
    hold_ticks = 0; prev_hold = holding;
    for (int i = 0; i < 24; i++) begin
      step();
      if (prev_hold && frame_tick) hold_ticks++;
      prev_hold = holding;
      n_checks++;
      if ({sel, pattern, holding, frame_tick} !== {m_sel, m_pat, m_pat, m_tick}) begin
        n_fail++;
        $display("FAIL trig_pulse: sel=%0d pat=%0b hold=%0b tick=%0b, want sel=%0d pat=%0b tick=%0b",
                 sel, pattern, holding, frame_tick, m_sel, m_pat, m_tick);
      end
    end
    n_checks++;
    if (hold_ticks != HF) begin
      n_fail++;
      $display("FAIL hold_len: %0d ticks while holding, want %0d", hold_ticks, HF);
    end
  endtask

  task automatic test_trigger_held();
    int entries;
    logic prev_hold;
    int plan [6][2];
    plan = '{'{1, 30}, '{0, 2}, '{1, 1}, '{0, 3}, '{1, 1}, '{0, 16}};
    enable = 1'b1;
    entries = 0; prev_hold = holding;
    foreach (plan[p]) begin
      trigger = 1'(plan[p][0]);
      for (int i = 0; i < plan[p][1]; i++) begin
        step();
        if (holding && !prev_hold) entries++;
        prev_hold = holding;
        n_checks++;
        if ({sel, pattern, holding, frame_tick} !== {m_sel, m_pat, m_pat, m_tick}) begin
          n_fail++;
          $display("FAIL trig_held: sel=%0d pat=%0b hold=%0b tick=%0b, want sel=%0d pat=%0b tick=%0b",
                   sel, pattern, holding, frame_tick, m_sel, m_pat, m_tick);
        end
      end
    end
    n_checks++;
    if (entries != 2) begin
      n_fail++;
      $display("FAIL hold_entries: %0d hold entries, want 2", entries);
    end
  endtask

  task automatic test_idle_hold_reset();
    logic [1:0] saved;
    enable = 1'b0; trigger = 1'b0;
    step(); step();
    saved = m_sel;
    trigger = 1'b1; step(); trigger = 1'b0;
    for (int i = 0; i < 20; i++) step();
    n_checks++;
    if ({holding, pattern, sel} !== {1'b0, 1'b0, saved}) begin
      n_fail++;
      $display("FAIL idle_hold_done: hold=%0b pat=%0b sel=%0d, want 0 0 %0d",
               holding, pattern, sel, saved);
    end
    trigger = 1'b1; step(); trigger = 1'b0;
    step(); step(); step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({sel, pattern, holding, frame_tick} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_mid_hold: sel=%0d pat=%0b hold=%0b tick=%0b, want all 0",
               sel, pattern, holding, frame_tick);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (frame_tick !== 1'b0 || sel !== m_sel) begin
        n_fail++;
        $display("FAIL rst_release: tick=%0b sel=%0d, want 0 %0d", frame_tick, sel, m_sel);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 11) == 0) trigger = ~trigger;
      dir = 1'($urandom_range(0, 1));
      step();
      n_checks++;
      if ({sel, pattern, holding, frame_tick} !== {m_sel, m_pat, m_pat, m_tick}) begin
        n_fail++;
        $display("FAIL random[%0d]: sel=%0d pat=%0b hold=%0b tick=%0b, want sel=%0d pat=%0b tick=%0b",
                 i, sel, pattern, holding, frame_tick, m_sel, m_pat, m_tick);
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef LED_ANIM_PINGPONG_EN
    test_pingpong();
`endif
    test_forward();
    test_reverse_pause();
    test_trigger_pulse();
    test_trigger_held();
    test_idle_hold_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_anim_ctrl.md
Name: led_anim_ctrl

Overview:
Sequencer that drives the 8x8 LED matrix scanner's `sel[1:0]` (animation frame) and `pattern` (alternate-image override) inputs. A clock prescaler sets the frame rate, and the block steps through the frames in order. A trigger pulse shows the alternate pattern for a fixed number of frames, then animation resumes. The block sits between the board buttons/switches and the matrix scanner.

Parameters:
- TICK_DIV, 25000000, clk cycles per animation frame; legal range ≥2.
- HOLD_FRAMES, 8, number of frame ticks the alternate pattern is held after a trigger; legal range ≥1.
- PS_W, 25, prescaler counter width; must satisfy 2^PS_W ≥ TICK_DIV.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-high.
- enable  in  1  run (1) / pause (0) of the frame stepping; synchronous level.
- trigger  in  1  request for the alternate pattern; synchronous; acts on its rising edge.
- dir  in  1  step direction: 0 = forward (sel+1), 1 = reverse (sel-1).
- sel  out  2  frame index to the matrix scanner; registered.
- pattern  out  1  alternate-pattern select to the matrix scanner; registered.
- frame_tick  out  1  one-cycle pulse, high in the first cycle a new frame period begins; registered.
- holding  out  1  high while in the HOLD state; registered.

Behaviour:
- Reset values (async, immediate):
  - sel=0, pattern=0, frame_tick=0, holding=0.
  - Prescaler count=0, hold count=0, trig_d=0, state=IDLE.
- Prescaler:
  - Runs when state=RUN, or state=HOLD (HOLD runs regardless of enable). Frozen otherwise.
  - Counts 0..TICK_DIV-1. When the count equals TICK_DIV-1 while running, the next edge sets count←0 and frame_tick←1. At every other edge frame_tick←0.
  - Pausing keeps the count value, so a resume continues the partial period. It does not restart the period.
- Trigger edge detection:
  - trig_d registers trigger every cycle.
  - trig_rise = trigger & ~trig_d, evaluated combinationally in the cycle trigger first reads 1.
- States:
  - IDLE:
    - sel held.
    - enable=1 → RUN at next edge.
    - trig_rise → HOLD (takes priority over enable).
  - RUN:
    - At the prescaler wrap edge: sel ← sel+1 (dir=0) or sel−1 (dir=1), modulo 4. Wrap-around is 3→0 forward and 0→3 reverse.
    - enable=0 → IDLE at next edge; a wrap coinciding with that edge is discarded, sel not stepped.
    - trig_rise → HOLD; priority over both enable and stepping, so sel does not step on that edge.
  - HOLD:
    - Entry edge: pattern←1, holding←1, hold count←0. sel frozen.
    - Each prescaler wrap increments the hold count.
    - At the wrap where hold count = HOLD_FRAMES-1: pattern←0, holding←0, next state = RUN if enable=1, else IDLE. sel still does not step on this edge.
    - trig_rise during HOLD is ignored; the hold is not extended.
- Hold latency: exactly HOLD_FRAMES wraps after entry. The first wrap is TICK_DIV minus the residual prescaler count away.
- pattern and holding always equal (state==HOLD), each registered with one edge of latency.
- dir may change at any time; it is sampled only at step edges.
- Reset mid-operation (any state) returns all registers to reset values immediately; no frame_tick is emitted on reset release.

Optional Feature:
- Macro: LED_ANIM_PINGPONG_EN.
- Defined: dir is ignored, and an internal direction bit (reset 0 = forward) sets the step direction. It reverses when sel reaches 3 going forward or 0 going reverse. Sequence: 0,1,2,3,2,1,0,1,… The direction bit is frozen in IDLE and HOLD.
- Undefined: direction comes from dir with modulo-4 wrap, as described in Behaviour.

Test Plan (TICK_DIV=4, HOLD_FRAMES=3):
1. Reset, enable=1, dir=0 for 20 cycles.
   → frame_tick every 4th cycle; sel 0→1→2→3→0 on consecutive ticks; pattern stays 0.
2. dir=1 from sel=0.
   → next tick sel=3, then 2.
   Pause 6 cycles mid-period and resume.
   → no tick or step while paused; the first tick after resume arrives after only the remaining count.
3. One-cycle trigger pulse in RUN at sel=2.
   → next edge pattern=1, holding=1, sel=2 held for 3 ticks.
   → on the 3rd tick pattern=0, holding=0; sel steps to 3 on the following tick.
4. Trigger held high 30 cycles, and a second rising edge during HOLD.
   → exactly one hold of 3 ticks; no re-entry until trigger falls and rises again.
5. Trigger with enable=0 (IDLE).
   → HOLD completes (prescaler runs), then IDLE with sel unchanged.
   Assert rst mid-HOLD.
   → sel=0, pattern=0, holding=0, frame_tick=0 immediately.
6. LED_ANIM_PINGPONG_EN defined, enable=1, 8 ticks.
   → sel sequence 1,2,3,2,1,0,1,2; dir toggling has no effect.
